// File: rtl/key_sw_io_pkg.sv
// key_sw_io_pkg: shared processor bus width, memory-mapped I/O addresses and open-bus read value.
package key_sw_io_pkg;
  localparam int DBITS = 16;
  localparam logic [15:0] ADDR_KDATA = 16'hFFF0;
  localparam logic [15:0] ADDR_SDATA = 16'hFFF2;
  localparam logic [15:0] ADDR_KCTRL = 16'hFFF4;
  localparam logic [15:0] ADDR_SCTRL = 16'hFFF6;
  localparam logic [15:0] ADDR_HEX   = 16'hFFF8;
  localparam logic [15:0] ADDR_LEDR  = 16'hFFFA;
  localparam logic [15:0] ADDR_LEDG  = 16'hFFFC;
  localparam logic [15:0] DOUT_IDLE  = 16'hDEAD;
endpackage

// File: rtl/debounce_bit.sv
// debounce_bit: 2-flop synchronizer plus stable-count debouncer for one board input.
// The output is always in "active" polarity, so it idles at 0 for keys and switches alike.
module debounce_bit #(
  parameter int DBN_CNT = 50000,
  parameter bit ACT_LOW = 1'b0
) (
  input  logic CLK,
  input  logic RESET_N,
  input  logic i_raw,
  output logic o_db
);
  localparam int CW = (DBN_CNT > 1) ? $clog2(DBN_CNT) : 1;
  localparam logic [CW-1:0] LAST = CW'(DBN_CNT - 1);
  logic r_sync1, r_sync2, r_db;
  logic [CW-1:0] r_cnt;
  logic w_act;
  assign w_act = r_sync2 ^ ACT_LOW;
  always_ff @(posedge CLK or negedge RESET_N)
    if (!RESET_N) begin
      r_sync1 <= ACT_LOW;
      r_sync2 <= ACT_LOW;
      r_db    <= 1'b0;
      r_cnt   <= '0;
    end else begin
      r_sync1 <= i_raw;
      r_sync2 <= r_sync1;
      if (w_act == r_db) r_cnt <= '0;
      else if (r_cnt == LAST) begin
        r_db  <= w_act;
        r_cnt <= '0;
      end else r_cnt <= r_cnt + CW'(1);
    end
  assign o_db = r_db;
endmodule

// File: rtl/key_sw_io.sv
// key_sw_io: debounced key/switch inputs exposed as memory-mapped data and
// sticky ready/overrun status registers with write-1-to-clear.
module key_sw_io #(
  parameter int DBITS   = key_sw_io_pkg::DBITS,
  parameter int DBN_CNT = 50000
) (
  input  logic             CLK,
  input  logic             RESET_N,
  input  logic [3:0]       KEY,
  input  logic [9:0]       SW,
  input  logic [DBITS-1:0] ADDR,
  input  logic [DBITS-1:0] DIN,
  input  logic             WE,
  output logic [DBITS-1:0] DOUT,
  output logic             SEL
);
  import key_sw_io_pkg::*;
  logic [3:0] w_kdb, r_kprev, r_krdy, r_kovr, w_kset, w_kclr, w_koclr;
  logic [9:0] w_sdb, r_sprev;
  logic r_srdy, r_sovr, w_sset, w_kctrl_we, w_sctrl_we;
  logic w_hit_kd, w_hit_sd, w_hit_kc, w_hit_sc;
  logic w_unused;
  genvar i;
  for (i = 0; i < 4; i++) begin : g_key
    debounce_bit #(.DBN_CNT(DBN_CNT), .ACT_LOW(1'b1)) u_db (
      .CLK(CLK), .RESET_N(RESET_N), .i_raw(KEY[i]), .o_db(w_kdb[i]));
  end
  for (i = 0; i < 10; i++) begin : g_sw
    debounce_bit #(.DBN_CNT(DBN_CNT), .ACT_LOW(1'b0)) u_db (
      .CLK(CLK), .RESET_N(RESET_N), .i_raw(SW[i]), .o_db(w_sdb[i]));
  end
  assign w_hit_kd   = ADDR == DBITS'(ADDR_KDATA);
  assign w_hit_sd   = ADDR == DBITS'(ADDR_SDATA);
  assign w_hit_kc   = ADDR == DBITS'(ADDR_KCTRL);
  assign w_hit_sc   = ADDR == DBITS'(ADDR_SCTRL);
  assign w_kctrl_we = WE && w_hit_kc;
  assign w_sctrl_we = WE && w_hit_sc;
  assign w_kset     = w_kdb & ~r_kprev;
  assign w_kclr     = w_kctrl_we ? DIN[3:0] : 4'b0;
  assign w_koclr    = w_kctrl_we ? DIN[7:4] : 4'b0;
  assign w_sset     = |(w_sdb ^ r_sprev);
  assign w_unused   = ^DIN[DBITS-1:8];
  // Set terms are OR-ed after the clear mask so a coincident set wins.
  always_ff @(posedge CLK or negedge RESET_N)
    if (!RESET_N) begin
      r_kprev <= '0;
      r_sprev <= '0;
      r_krdy  <= '0;
      r_kovr  <= '0;
      r_srdy  <= 1'b0;
      r_sovr  <= 1'b0;
    end else begin
      r_kprev <= w_kdb;
      r_sprev <= w_sdb;
      r_krdy  <= (r_krdy & ~w_kclr) | w_kset;
      r_kovr  <= (r_kovr & ~w_koclr) | (w_kset & r_krdy);
      r_srdy  <= (r_srdy & ~(w_sctrl_we & DIN[0])) | w_sset;
      r_sovr  <= (r_sovr & ~(w_sctrl_we & DIN[1])) | (w_sset & r_srdy);
    end
  always_comb begin
    SEL  = w_hit_kd | w_hit_sd | w_hit_kc | w_hit_sc;
    DOUT = w_hit_kd ? DBITS'({12'b0, w_kdb}) :
           w_hit_sd ? DBITS'({6'b0, w_sdb}) :
           w_hit_kc ? DBITS'({8'b0, r_kovr, r_krdy}) :
           w_hit_sc ? DBITS'({14'b0, r_sovr, r_srdy}) :
                      DBITS'(DOUT_IDLE);
  end
endmodule

// File: tb/tb_key_sw_io.sv
// tb_key_sw_io: directed scenarios plus random key/switch/bus traffic checked
// against a window-based behavioural model of debounce and status flags.
module tb_key_sw_io;
  localparam int DBN = 4;
  logic CLK = 1'b0;
  logic RESET_N, WE, SEL;
  logic [3:0] KEY;
  logic [9:0] SW;
  logic [15:0] ADDR, DIN, DOUT;
  int n_chk = 0, n_pass = 0;
  logic [13:0] q_raw[$];
  logic [13:0] q_s[$];
  logic [13:0] m_db, m_dbp;
  logic [3:0] m_krdy, m_kovr;
  logic m_srdy, m_sovr;

  always #5 CLK = ~CLK;

  key_sw_io #(.DBITS(16), .DBN_CNT(DBN)) dut (
    .CLK(CLK), .RESET_N(RESET_N), .KEY(KEY), .SW(SW), .ADDR(ADDR),
    .DIN(DIN), .WE(WE), .DOUT(DOUT), .SEL(SEL));

  task automatic m_reset();
    q_raw = {};
    q_raw.push_back(14'h0);
    q_raw.push_back(14'h0);
    q_s = {};
    m_db = '0;
    m_dbp = '0;
    m_krdy = '0;
    m_kovr = '0;
    m_srdy = 1'b0;
    m_sovr = 1'b0;
  endtask

  // Inputs held in active polarity {SW, pressed}; a level is accepted once the
  // last DBN synchronized samples (raw delayed two clocks) all differ from it.
  task automatic m_edge();
    logic [13:0] s, nd;
    logic [3:0] kset, kc, koc;
    logic sset, sc, soc, all;
    if (!RESET_N) begin
      m_reset();
      return;
    end
    kset = m_db[3:0] & ~m_dbp[3:0];
    sset = m_db[13:4] != m_dbp[13:4];
    kc  = (WE && ADDR == 16'hFFF4) ? DIN[3:0] : 4'h0;
    koc = (WE && ADDR == 16'hFFF4) ? DIN[7:4] : 4'h0;
    sc  = WE && ADDR == 16'hFFF6 && DIN[0];
    soc = WE && ADDR == 16'hFFF6 && DIN[1];
    m_kovr = (m_kovr & ~koc) | (kset & m_krdy);
    m_krdy = (m_krdy & ~kc) | kset;
    m_sovr = (m_sovr & ~soc) | (sset & m_srdy);
    m_srdy = (m_srdy & ~sc) | sset;
    q_raw.push_back({SW, ~KEY});
    s = q_raw.pop_front();
    q_s.push_back(s);
    if (q_s.size() > DBN) void'(q_s.pop_front());
    nd = m_db;
    if (q_s.size() == DBN)
      for (int b = 0; b < 14; b++) begin
        all = 1'b1;
        foreach (q_s[j]) if (q_s[j][b] == m_db[b]) all = 1'b0;
        if (all) nd[b] = s[b];
      end
    m_dbp = m_db;
    m_db = nd;
  endtask

  function automatic logic [15:0] m_dout(input logic [15:0] a);
    case (a)
      16'hFFF0: return {12'h0, m_db[3:0]};
      16'hFFF2: return {6'h0, m_db[13:4]};
      16'hFFF4: return {8'h0, m_kovr, m_krdy};
      16'hFFF6: return {14'h0, m_sovr, m_srdy};
      default:  return 16'hDEAD;
    endcase
  endfunction

  task automatic cyc(input int n = 1);
    repeat (n) begin
      @(posedge CLK);
      m_edge();
      #1;
      WE = 1'b0;
    end
  endtask

  task automatic chk(input logic [15:0] a, input logic [15:0] e, input logic es, input string tag);
    ADDR = a;
    #1;
    n_chk++;
    assert (DOUT === e && SEL === es) n_pass++;
    else $error("FAIL %s @%h: DOUT=%h SEL=%b expected DOUT=%h SEL=%b", tag, a, DOUT, SEL, e, es);
  endtask

  task automatic chk_model(input string tag);
    for (int k = 0; k < 4; k++) begin
      logic [15:0] a;
      a = 16'hFFF0 + 16'(2 * k);
      chk(a, m_dout(a), 1'b1, tag);
    end
  endtask

  task automatic wr(input logic [15:0] a, input logic [15:0] d);
    WE = 1'b1;
    ADDR = a;
    DIN = d;
    cyc(1);
  endtask

  initial begin
    RESET_N = 1'b0;
    KEY = 4'hF;
    SW = '0;
    WE = 1'b0;
    ADDR = '0;
    DIN = '0;
    m_reset();
    cyc(3);
    RESET_N = 1'b1;
    chk(16'hFFF0, 16'h0000, 1'b1, "rst_kdata");
    chk(16'hFFF2, 16'h0000, 1'b1, "rst_sdata");
    chk(16'hFFF4, 16'h0000, 1'b1, "rst_kctrl");
    chk(16'hFFF6, 16'h0000, 1'b1, "rst_sctrl");
    // Clean press of KEY[0]: data at 6 clocks, ready flag one clock later.
    KEY = 4'b1110;
    cyc(5);
    chk(16'hFFF0, 16'h0000, 1'b1, "k0_early");
    cyc(1);
    chk(16'hFFF0, 16'h0001, 1'b1, "k0_kdata");
    chk(16'hFFF4, 16'h0000, 1'b1, "k0_kctrl_pre");
    cyc(1);
    chk(16'hFFF4, 16'h0001, 1'b1, "k0_kctrl");
    KEY = 4'hF;
    cyc(8);
    chk(16'hFFF0, 16'h0000, 1'b1, "k0_release");
    chk(16'hFFF4, 16'h0001, 1'b1, "k0_release_nochg");
    wr(16'hFFF4, 16'hFFFF);
    chk(16'hFFF4, 16'h0000, 1'b1, "k0_w1c");
    // Short glitch on KEY[2] is rejected.
    KEY = 4'b1011;
    cyc(3);
    KEY = 4'hF;
    cyc(8);
    chk(16'hFFF0, 16'h0000, 1'b1, "glitch_kdata");
    chk(16'hFFF4, 16'h0000, 1'b1, "glitch_kctrl");
    // Two presses of KEY[1] without a clear produce an overrun.
    KEY = 4'b1101;
    cyc(8);
    chk(16'hFFF4, 16'h0002, 1'b1, "k1_first");
    KEY = 4'hF;
    cyc(8);
    KEY = 4'b1101;
    cyc(8);
    KEY = 4'hF;
    cyc(8);
    chk(16'hFFF4, 16'h0022, 1'b1, "k1_ovr");
    wr(16'hFFF4, 16'h0022);
    chk(16'hFFF4, 16'h0000, 1'b1, "k1_w1c");
    chk_model("model_keys");
    // Switches: set, then a clear that coincides with the next change.
    SW = 10'h3FF;
    cyc(8);
    chk(16'hFFF2, 16'h03FF, 1'b1, "sw_sdata");
    chk(16'hFFF6, 16'h0001, 1'b1, "sw_sctrl");
    SW = 10'h000;
    cyc(6);
    wr(16'hFFF6, 16'h0001);
    chk(16'hFFF6, 16'h0003, 1'b1, "sw_set_wins");
    chk(16'hFFF2, 16'h0000, 1'b1, "sw_sdata_fall");
    wr(16'hFFF6, 16'h0003);
    chk(16'hFFF6, 16'h0000, 1'b1, "sw_w1c");
    // Reset in the middle of a KEY[3] press restarts the debounce.
    KEY = 4'b0111;
    cyc(3);
    RESET_N = 1'b0;
    m_reset();
    cyc(2);
    RESET_N = 1'b1;
    cyc(5);
    chk(16'hFFF0, 16'h0000, 1'b1, "rst_mid_early");
    cyc(1);
    chk(16'hFFF0, 16'h0008, 1'b1, "rst_mid_kdata");
    // Unmapped reads and ignored data-register writes.
    chk(16'hFFF8, 16'hDEAD, 1'b0, "unmapped_fff8");
    chk(16'hFFEE, 16'hDEAD, 1'b0, "unmapped_ffee");
    chk(16'hFFF1, 16'hDEAD, 1'b0, "unmapped_odd");
    wr(16'hFFF0, 16'hFFFF);
    chk(16'hFFF0, 16'h0008, 1'b1, "kdata_wr_ignored");
    wr(16'hFFF2, 16'hFFFF);
    chk(16'hFFF2, 16'h0000, 1'b1, "sdata_wr_ignored");
    chk_model("model_directed");
    // Random inputs, glitches and bus writes against the model.
    for (int n = 0; n < 500; n++) begin
      if ($urandom_range(0, 2) == 0) begin
        int b;
        b = ($urandom_range(0, 1) == 0) ? int'($urandom_range(0, 5)) : int'($urandom_range(0, 13));
        if (b < 4) KEY[b] = ~KEY[b];
        else SW[b-4] = ~SW[b-4];
      end
      if ($urandom_range(0, 5) == 0) begin
        logic [15:0] wa;
        case ($urandom_range(0, 5))
          0: wa = 16'hFFF0;
          1: wa = 16'hFFF2;
          2, 3: wa = 16'hFFF4;
          4: wa = 16'hFFF6;
          default: wa = 16'($urandom);
        endcase
        WE = 1'b1;
        ADDR = wa;
        DIN = 16'($urandom);
      end
      cyc(1);
      chk_model("rand");
    end
    chk(16'hFFFA, 16'hDEAD, 1'b0, "unmapped_fffa");
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
